fproc_requester: RTL and testbench
==================================

Name: fproc_requester

Overview:
Core-side initiator for the function-processor request/response channel, the counterpart to the fproc responders such as the measurement-result server. It accepts a single request (function id) from the core pipeline and drives a one-cycle enable with a stable id toward the responder. It then waits for the responder's ready pulse, captures the returned data and presents it to the core with a valid/ready handshake. A timeout guarantees forward progress if the responder never answers.

Parameters:
ID_WIDTH, 8, width of function/measurement id driven to responder
DATA_WIDTH, 32, width of response data
TIMEOUT_CYCLES, 64, max cycles waited for fproc_ready after enable; must be >= 2
CNT_WIDTH, $clog2(TIMEOUT_CYCLES+1), wait-counter width (derived, not overridden)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous active-low reset
req_valid  input  1  core presents request
req_id  input  ID_WIDTH  function id of request
req_ready  output  1  requester can accept (high only in IDLE)
fproc_enable  output  1  one-cycle request strobe to responder
fproc_id  output  ID_WIDTH  id to responder, held stable ISSUE through WAIT
fproc_ready  input  1  responder data-valid pulse
fproc_data  input  DATA_WIDTH  responder data, sampled when fproc_ready=1
resp_valid  output  1  response available to core
resp_data  output  DATA_WIDTH  captured data (0 on timeout)
resp_timeout  output  1  response produced by timeout, qualified by resp_valid
resp_ready  input  1  core consumes response

Behaviour:
- Clock clk, reset async active-low: reset=0 forces state IDLE immediately, independent of clk.
- Reset values: req_ready=0 while reset asserted, 1 in first IDLE cycle after release. fproc_enable=0, fproc_id=0, resp_valid=0, resp_data=0, resp_timeout=0, counter=0.
- All outputs registered (req_ready decoded from state register only).
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE: req_ready=1. On req_valid=1 at edge: latch req_id into fproc_id, go ISSUE.
- ISSUE: fproc_enable=1 for exactly this cycle. Go WAIT, counter cleared to 0.
- WAIT: fproc_enable=0, fproc_id held.
  - fproc_ready=1: capture fproc_data into resp_data, resp_timeout=0, resp_valid=1, go DONE.
  - Else counter+1. When counter reaches TIMEOUT_CYCLES-1 with no ready: resp_data=0, resp_timeout=1, resp_valid=1, go DONE.
  - fproc_ready on the same edge as timeout expiry: ready wins (real data, resp_timeout=0).
- DONE: resp_valid, resp_data and resp_timeout held stable until resp_ready=1. On that edge: resp_valid=0, go IDLE. No new request is accepted in DONE.
- Latency: request accepted at edge 0; enable high cycle 1. Against a 2-cycle responder, ready is seen in cycle 3 and resp_valid is high in cycle 4. Minimum request-to-request spacing is 4 cycles with resp_ready tied high.
- fproc_ready in IDLE, ISSUE or DONE is ignored. A late ready arriving after timeout does not alter a held response.
- A reset asserted mid-operation discards the in-flight request. A responder ready arriving after reset release is ignored (state IDLE).
- fproc_id keeps the last id after return to IDLE; it is only updated on acceptance.

Optional Feature:
FPROC_REQ_STATS_EN
- Defined: adds outputs stat_ok_count[15:0] and stat_timeout_count[15:0].
  - stat_ok_count increments on each WAIT->DONE transition with real data.
  - stat_timeout_count increments on each timeout.
  - Both counters saturate at 16'hFFFF and are cleared by reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Responder with 2-cycle latency returns 32'h1 for id 3; req_id=3 accepted at edge 0 -> fproc_enable high only in cycle 1, fproc_id=3, resp_valid=1 in cycle 4, resp_data=32'h1, resp_timeout=0.
- Responder silent, TIMEOUT_CYCLES=8 -> resp_valid rises 9 cycles after enable cycle, resp_timeout=1, resp_data=0. A later ready pulse does not change the held response.
- resp_ready held low 5 cycles after response -> resp_valid/resp_data stable for all 5 cycles, req_ready=0; on resp_ready=1, req_ready=1 the next cycle.
- reset pulsed low during WAIT (id 7) -> outputs zero asynchronously; responder ready arriving 1 cycle after release is ignored; next request id 2 completes normally.
- fproc_ready pulsed while IDLE with no request -> no resp_valid, state stays IDLE; ready coincident with timeout expiry -> resp_timeout=0, data captured.
- With FPROC_REQ_STATS_EN: 3 good requests and 2 timeouts -> stat_ok_count=3, stat_timeout_count=2. Force saturation -> counter holds 16'hFFFF.

Source files
------------

// File: rtl/fproc_requester.sv
// Core-side initiator: one request -> one-cycle enable to responder, waits for ready or timeout, returns data.
// Latency: enable 1 cycle after acceptance, resp_valid 1 cycle after fproc_ready (or timeout expiry).
// Backpressure: req_ready only in IDLE; the response is held until resp_ready. FPROC_REQ_STATS_EN adds counters.
module fproc_requester #(
    parameter int ID_WIDTH       = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64,
    localparam int CNT_WIDTH     = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic [ID_WIDTH-1:0]   req_id,
    output logic                  req_ready,
    output logic                  fproc_enable,
    output logic [ID_WIDTH-1:0]   fproc_id,
    input  logic                  fproc_ready,
    input  logic [DATA_WIDTH-1:0] fproc_data,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_timeout,
    input  logic                  resp_ready
`ifdef FPROC_REQ_STATS_EN
    ,
    output logic [15:0]           stat_ok_count,
    output logic [15:0]           stat_timeout_count
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    state_t                state_q, state_d;
    logic                  enable_d;
    logic [ID_WIDTH-1:0]   id_d;
    logic                  valid_d;
    logic [DATA_WIDTH-1:0] data_d;
    logic                  timeout_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // Gated by reset so the core never sees ready while the block is held in reset.
    assign req_ready = (state_q == S_IDLE) & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            fproc_enable <= 1'b0;
            fproc_id     <= '0;
            resp_valid   <= 1'b0;
            resp_data    <= '0;
            resp_timeout <= 1'b0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            fproc_enable <= enable_d;
            fproc_id     <= id_d;
            resp_valid   <= valid_d;
            resp_data    <= data_d;
            resp_timeout <= timeout_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        enable_d  = 1'b0;
        id_d      = fproc_id;
        valid_d   = resp_valid;
        data_d    = resp_data;
        timeout_d = resp_timeout;
        cnt_d     = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    id_d     = req_id;
                    enable_d = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // A ready on the expiry edge still delivers real data.
                if (fproc_ready) begin
                    data_d    = fproc_data;
                    timeout_d = 1'b0;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d    = '0;
                    timeout_d = 1'b1;
                    valid_d   = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    valid_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef FPROC_REQ_STATS_EN
    logic ok_inc;
    logic to_inc;

    assign ok_inc = (state_q == S_WAIT) & fproc_ready;
    assign to_inc = (state_q == S_WAIT) & ~fproc_ready & (cnt_q == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_ok_count      <= '0;
            stat_timeout_count <= '0;
        end else begin
            if (ok_inc && (stat_ok_count != 16'hFFFF))
                stat_ok_count <= stat_ok_count + 16'd1;
            if (to_inc && (stat_timeout_count != 16'hFFFF))
                stat_timeout_count <= stat_timeout_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fproc_requester.sv
// Directed bench for fproc_requester: stimulus pushes expected responses, a negedge monitor pops and compares.
// Runs with TIMEOUT_CYCLES=8; FPROC_REQ_STATS_EN enables the counter checks.
module tb_fproc_requester;

    localparam int IDW = 8;
    localparam int DW  = 32;
    localparam int TO  = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req_valid = 1'b0;
    logic [IDW-1:0] req_id = '0;
    logic           req_ready;
    logic           fproc_enable;
    logic [IDW-1:0] fproc_id;
    logic           fproc_ready = 1'b0;
    logic [DW-1:0]  fproc_data = '0;
    logic           resp_valid;
    logic [DW-1:0]  resp_data;
    logic           resp_timeout;
    logic           resp_ready = 1'b1;
`ifdef FPROC_REQ_STATS_EN
    logic [15:0]    stat_ok_count;
    logic [15:0]    stat_timeout_count;
`endif

    int errors = 0;
    int checks = 0;
    logic [DW:0] exp_q[$];

    fproc_requester #(
        .ID_WIDTH      (IDW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_id      (req_id),
        .req_ready   (req_ready),
        .fproc_enable(fproc_enable),
        .fproc_id    (fproc_id),
        .fproc_ready (fproc_ready),
        .fproc_data  (fproc_data),
        .resp_valid  (resp_valid),
        .resp_data   (resp_data),
        .resp_timeout(resp_timeout),
        .resp_ready  (resp_ready)
`ifdef FPROC_REQ_STATS_EN
        ,
        .stat_ok_count     (stat_ok_count),
        .stat_timeout_count(stat_timeout_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted response is compared against the oldest expectation.
    always @(negedge clk) begin
        if (reset && resp_valid && resp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_resp", 32'(resp_valid), 32'd0);
            end else begin
                logic [DW:0] e;
                e = exp_q.pop_front();
                chk("sb_data", resp_data, e[DW-1:0]);
                chk("sb_timeout", 32'(resp_timeout), 32'(e[DW]));
            end
        end
    end

    // Starts in an IDLE cycle; returns in the cycle resp_valid is first seen (or budget expiry).
    // rdy_cyc: cycle (1 = enable cycle) in which the responder pulses ready, 0 = silent.
    task automatic run_req(input logic [IDW-1:0] id, input int rdy_cyc, input logic [DW-1:0] dat,
                           input int exp_lat, input bit exp_to, input bit finish);
        int cyc;
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        exp_q.push_back({exp_to, exp_to ? 32'd0 : dat});
        req_valid = 1'b1;
        req_id    = id;
        tick();
        req_valid = 1'b0;
        cyc = 1;
        chk("enable_issue", 32'(fproc_enable), 32'd1);
        chk("fproc_id", 32'(fproc_id), 32'(id));
        chk("req_ready_busy", 32'(req_ready), 32'd0);
        while (!resp_valid && cyc < 40) begin
            if (cyc == rdy_cyc) begin
                fproc_ready = 1'b1;
                fproc_data  = dat;
            end else begin
                fproc_ready = 1'b0;
                fproc_data  = 32'hBAD0_0000;
            end
            tick();
            cyc++;
            if (cyc == 2) chk("enable_one_cycle", 32'(fproc_enable), 32'd0);
        end
        fproc_ready = 1'b0;
        chk("resp_latency", 32'(cyc), 32'(exp_lat));
        if (finish) begin
            tick();
            chk("resp_valid_clear", 32'(resp_valid), 32'd0);
            chk("req_ready_back", 32'(req_ready), 32'd1);
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_enable", 32'(fproc_enable), 32'd0);
        chk("rst_id", 32'(fproc_id), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_timeout", 32'(resp_timeout), 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("first_idle_ready", 32'(req_ready), 32'd1);
        tick();

        // 2-cycle responder, then 1-cycle responder
        run_req(8'd3, 3, 32'h0000_0001, 4, 1'b0, 1'b1);
        run_req(8'hAB, 2, 32'hFFFF_FFFF, 3, 1'b0, 1'b1);

        // Silent responder: timeout 9 cycles after the enable cycle
        run_req(8'd6, 0, 32'h1234_5678, 10, 1'b1, 1'b1);

        // Consumer stall for 5 cycles
        resp_ready = 1'b0;
        run_req(8'd5, 3, 32'hCAFE_0005, 4, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(resp_valid), 32'd1);
            chk("stall_data", resp_data, 32'hCAFE_0005);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        tick();
        chk("stall_release_ready", 32'(req_ready), 32'd1);

        // Late ready after timeout must not disturb the held response
        resp_ready = 1'b0;
        run_req(8'd9, 0, 32'h9999_9999, 10, 1'b1, 1'b0);
        fproc_ready = 1'b1;
        fproc_data  = 32'hDEAD_BEEF;
        tick();
        fproc_ready = 1'b0;
        chk("late_data", resp_data, 32'd0);
        chk("late_timeout", 32'(resp_timeout), 32'd1);
        resp_ready = 1'b1;
        tick();
        chk("late_release_ready", 32'(req_ready), 32'd1);

        // Ready pulse in IDLE with no request
        fproc_ready = 1'b1;
        fproc_data  = 32'h5555_AAAA;
        tick();
        fproc_ready = 1'b0;
        chk("idle_pulse_valid", 32'(resp_valid), 32'd0);
        chk("idle_pulse_ready", 32'(req_ready), 32'd1);
        tick();
        chk("idle_pulse_valid2", 32'(resp_valid), 32'd0);

        // Ready coincident with timeout expiry: data wins
        run_req(8'd4, TO + 1, 32'h0000_0444, 10, 1'b0, 1'b1);

        // Reset during WAIT (id 7)
        req_valid = 1'b1;
        req_id    = 8'd7;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_id", 32'(fproc_id), 32'd0);
        chk("arst_enable", 32'(fproc_enable), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        chk("arst_resp_valid", 32'(resp_valid), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        fproc_ready = 1'b1;
        fproc_data  = 32'h7777_7777;
        tick();
        fproc_ready = 1'b0;
        chk("post_rst_valid", 32'(resp_valid), 32'd0);
        chk("post_rst_ready", 32'(req_ready), 32'd1);
        run_req(8'd2, 3, 32'h0000_2222, 4, 1'b0, 1'b1);

        // More traffic after reset: 2 good, 2 timeouts
        for (int i = 0; i < 2; i++)
            run_req(IDW'(8'h10 + i), 3, 32'hA5A5_0000 + 32'(i), 4, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++)
            run_req(IDW'(8'h20 + i), 0, 32'h0F0F_0F0F, 10, 1'b1, 1'b1);

`ifdef FPROC_REQ_STATS_EN
        chk("stat_ok", 32'(stat_ok_count), 32'd3);
        chk("stat_timeout", 32'(stat_timeout_count), 32'd2);
        force dut.stat_ok_count = 16'hFFFF;
        tick();
        release dut.stat_ok_count;
        run_req(8'h30, 3, 32'h0000_0030, 4, 1'b0, 1'b1);
        chk("stat_ok_sat", 32'(stat_ok_count), 32'h0000_FFFF);
`endif

        tick();
        chk("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
